// File: rtl/coco_dump.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | coco_dump: scans a count sketch and emits buckets that pass a count filter  |
// | through a 4-entry valid/ready FIFO. Macro COCO_DUMP_THRESH_EN selects the   |
// | threshold filter; otherwise any non-zero count passes.                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module coco_dump #(
  parameter int LENGTH = 65536,
  parameter int ADDR_W = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       threshold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [31:0]       id_rdata,
  input  logic [31:0]       cnt_rdata,
  output logic [31:0]       out_id,
  output logic [31:0]       out_cnt,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         thr_q, thr_d;
  logic                inflight_q;
  logic [ADDR_W-1:0]   inflight_addr_q;

  logic [31:0]         fifo_id_q   [4];
  logic [31:0]         fifo_cnt_q  [4];
  logic [ADDR_W-1:0]   fifo_addr_q [4];
  logic [1:0]          wr_ptr_q, rd_ptr_q;
  logic [2:0]          count_q;

  logic                w_issue, w_pass, w_push, w_pop;
  logic [2:0]          w_free;

  // A read is only launched when the FIFO can absorb it plus the one in flight,
  // so a push never meets a full FIFO.
  assign w_free  = 3'd4 - count_q;
  assign w_issue = (state_q == S_SCAN) && (w_free > {2'b00, inflight_q});

`ifdef COCO_DUMP_THRESH_EN
  assign w_pass = (cnt_rdata >= thr_q);
`else
  // Threshold is kept but has no effect on the filter in this build.
  assign w_pass = (cnt_rdata != 32'd0) | (&{1'b0, thr_q});
`endif

  assign w_push = inflight_q && w_pass;
  assign w_pop  = out_valid && out_ready;

  assign out_valid = (count_q != 3'd0);
  assign out_id    = fifo_id_q[rd_ptr_q];
  assign out_cnt   = fifo_cnt_q[rd_ptr_q];
  assign out_addr  = fifo_addr_q[rd_ptr_q];
  assign ram_en    = w_issue;
  assign ram_addr  = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    thr_d   = thr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = '0;
          thr_d   = threshold;
        end
      end
      S_SCAN: begin
        if (w_issue) begin
          if (addr_q == LAST_ADDR) state_d = S_DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (count_q == 3'd0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      thr_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_id_q[i]   <= '0;
        fifo_cnt_q[i]  <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      thr_q           <= thr_d;
      inflight_q      <= w_issue;
      inflight_addr_q <= addr_q;
      if (w_push) begin
        fifo_id_q[wr_ptr_q]   <= id_rdata;
        fifo_cnt_q[wr_ptr_q]  <= cnt_rdata;
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coco_dump.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for coco_dump with LENGTH=32: behavioural dual RAM, FIFO
// output monitor and immediate-assertion checks against hand-derived records.
module tb_coco_dump;
  localparam int LEN = 32;
  localparam int AW  = 5;

  typedef logic [68:0] rec_t;   // {addr, id, cnt}

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [31:0]   threshold;
  logic          busy, done, ram_en, out_valid;
  logic [AW-1:0] ram_addr, out_addr;
  logic [31:0]   id_rdata, cnt_rdata, out_id, out_cnt;

  logic [31:0]   id_mem  [LEN];
  logic [31:0]   cnt_mem [LEN];

  rec_t got_q[$];
  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic prev_hold = 1'b0;
  rec_t prev_rec;

  always #5 clk = ~clk;

  coco_dump #(.LENGTH(LEN), .ADDR_W(AW)) dut (
    .sys_clk   (clk),
    .rst_n     (rst_n),
    .start     (start),
    .threshold (threshold),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_en    (ram_en),
    .id_rdata  (id_rdata),
    .cnt_rdata (cnt_rdata),
    .out_id    (out_id),
    .out_cnt   (out_cnt),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      id_rdata  <= id_mem[ram_addr];
      cnt_rdata <= cnt_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records transfers, checks hold-stability and done cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 96'(out_valid), 96'(1'b1));
        chk("hold_data", 96'({out_addr, out_id, out_cnt}), 96'(prev_rec));
      end
      if (out_valid && out_ready) got_q.push_back({out_addr, out_id, out_cnt});
      if (done) begin
        done_cnt = done_cnt + 1;
        chk("done_valid_low", 96'(out_valid), 96'(1'b0));
      end
      prev_hold <= out_valid && !out_ready;
      prev_rec  <= {out_addr, out_id, out_cnt};
    end
  end

  function automatic bit passes(input logic [31:0] c, input logic [31:0] t);
`ifdef COCO_DUMP_THRESH_EN
    return c >= t;
`else
    return (c != 32'd0) || (t != t);
`endif
  endfunction

  task automatic build_exp(input logic [31:0] thr);
    exp_q.delete();
    for (int i = 0; i < LEN; i++)
      if (passes(cnt_mem[i], thr)) exp_q.push_back({AW'(i), id_mem[i], cnt_mem[i]});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      96'(busy),      96'(0));
    chk({tag, "_done"},      96'(done),      96'(0));
    chk({tag, "_ram_en"},    96'(ram_en),    96'(0));
    chk({tag, "_ram_addr"},  96'(ram_addr),  96'(0));
    chk({tag, "_out_valid"}, 96'(out_valid), 96'(0));
    chk({tag, "_out_id"},    96'(out_id),    96'(0));
    chk({tag, "_out_cnt"},   96'(out_cnt),   96'(0));
    chk({tag, "_out_addr"},  96'(out_addr),  96'(0));
  endtask

  // rmode 0: out_ready always high; 1: high one cycle in three.
  task automatic do_scan(input string tag, input logic [31:0] thr, input int rmode,
                         input bit mid, input bit lat, input int exp_n);
    int   done_edge;
    rec_t r;
    done_edge = -1;
    got_q.delete();
    done_cnt  = 0;
    build_exp(thr);
    out_ready = (rmode == 0);
    threshold = thr;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 96'(busy), 96'(1));
    for (int e = 1; e <= 400; e++) begin
      out_ready = (rmode == 0) ? 1'b1 : ((e % 3) == 0);
      start     = mid && (e == 5);
      if (mid && e == 5) threshold = 32'd5;
      @(posedge clk); #1;
      if (lat && e == 1) chk({tag, "_lat1_valid"}, 96'(out_valid), 96'(0));
      if (lat && e == 2) chk({tag, "_lat2_valid"}, 96'(out_valid), 96'(1));
      if (done && done_edge < 0) done_edge = e;
      if (!busy) break;
    end
    start = 1'b0;
    chk({tag, "_finished"}, 96'(busy), 96'(0));
    @(negedge clk); #1;
    chk({tag, "_done_pulses"}, 96'(done_cnt), 96'(1));
    chk({tag, "_n_records"}, 96'(got_q.size()), 96'(exp_n));
    for (int i = 0; i < exp_q.size(); i++) begin
      r = (i < got_q.size()) ? got_q[i] : 'x;
      chk($sformatf("%s_rec%0d", tag, i), 96'(r), 96'(exp_q[i]));
    end
    if (lat) chk({tag, "_done_edge"}, 96'(done_edge), 96'(35));
  endtask

  int n_idx;
  int n_zero;
  bit found;

  initial begin
`ifdef COCO_DUMP_THRESH_EN
    n_idx  = 12;   // addresses 20..31
    n_zero = 32;
`else
    n_idx  = 31;   // addresses 1..31
    n_zero = 0;
`endif
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; threshold = 32'd0;
    for (int i = 0; i < LEN; i++) begin
      id_mem[i]  = 32'hA000_0000 + i;
      cnt_mem[i] = i;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_scan("idx_ready", 32'd20, 0, 1'b0, 1'b0, n_idx);
    do_scan("idx_toggle", 32'd20, 1, 1'b0, 1'b0, n_idx);
    do_scan("idx_restart", 32'd20, 0, 1'b1, 1'b0, n_idx);

    for (int i = 0; i < LEN; i++) cnt_mem[i] = 32'd0;
    do_scan("zeros", 32'd0, 0, 1'b0, 1'b0, n_zero);

    for (int i = 0; i < LEN; i++) cnt_mem[i] = i + 1;
    do_scan("allpass", 32'd0, 0, 1'b0, 1'b1, 32);

    for (int i = 0; i < LEN; i++) cnt_mem[i] = 32'd0;
    cnt_mem[3] = 32'hFFFF_FFFF;
    do_scan("maxcnt", 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1);

    // Abort mid-scan with reset, then rescan.
    for (int i = 0; i < LEN; i++) cnt_mem[i] = i;
    out_ready = 1'b1;
    threshold = 32'd20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 60; e++) begin
      if (ram_en && ram_addr == AW'(10)) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("abort_reached_addr10", 96'(found), 96'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("abort_hold");
    chk("abort_no_done", 96'(done_cnt), 96'(0));
    rst_n = 1'b1;
    do_scan("after_abort", 32'd20, 0, 1'b0, 1'b0, n_idx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
